beta_exe_lsu: RTL and testbench

- Load & Store Unit in the execute stage, driven by the execute control unit through lsu_en/lsu_op/lsu_op_size.
- Reports back through lsu_busy.
- Translates one scalar RV32 load/store into a single request/grant/response transaction on the data-memory port.
- Handles byte-lane steering, load sign/zero extension, misalignment detection and bus-error reporting.

---
 rtl/beta_exe_lsu_if.sv | 26 ++
 rtl/beta_exe_lsu.sv | 129 ++++++++++++
 tb/tb_beta_exe_lsu.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/beta_exe_lsu_if.sv
// Data-memory port of the execute-stage LSU: request/grant address phase
// followed by a single rvalid response phase.
interface beta_exe_lsu_if #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32
);
  logic                 data_req_o;
  logic                 data_gnt_i;
  logic [AddrWidth-1:0] data_addr_o;
  logic                 data_we_o;
  logic [3:0]           data_be_o;
  logic [DataWidth-1:0] data_wdata_o;
  logic                 data_rvalid_i;
  logic                 data_err_i;
  logic [DataWidth-1:0] data_rdata_i;

  modport master (
    output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
    input  data_gnt_i, data_rvalid_i, data_err_i, data_rdata_i
  );

  modport slave (
    input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
    output data_gnt_i, data_rvalid_i, data_err_i, data_rdata_i
  );
endinterface

// File: rtl/beta_exe_lsu.sv
// Execute-stage load/store unit: turns one RV32 scalar load/store into a single
// request/grant/response transaction with lane steering and load extension.
module beta_exe_lsu #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 lsu_en_i,
  input  logic                 lsu_op_i,
  input  logic [1:0]           lsu_op_size_i,
  input  logic                 lsu_unsigned_i,
  input  logic [AddrWidth-1:0] lsu_addr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic                 lsu_busy_o,
  output logic [DataWidth-1:0] lsu_rdata_o,
  output logic                 lsu_misaligned_o,
  output logic                 lsu_fault_o,
  beta_exe_lsu_if.master       data_if
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] WAIT    = 2'd2;
  localparam logic [1:0] ERR     = 2'd3;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  logic [1:0]           state_q, state_d;
  logic                 en_q, op_q, uns_q, busy_q, fault_q;
  logic [1:0]           size_q;
  logic [AddrWidth-1:0] addr_q;
  logic [3:0]           be_q, be_d;
  logic [DataWidth-1:0] wdata_q, wdata_d, rdata_q;
  logic                 start, misaligned, rsp, rsp_load;

  // Align the addressed lanes down to bit 0, then sign/zero extend.
  function automatic logic [DataWidth-1:0] load_extend(
    input logic [DataWidth-1:0] raw,
    input logic [1:0]           size,
    input logic                 uns,
    input logic [1:0]           off
  );
    logic [DataWidth-1:0] shifted;
    shifted = raw >> {off, 3'b000};
    case (size)
      SZ_BYTE: load_extend = {{(DataWidth-8){shifted[7] & ~uns}}, shifted[7:0]};
      SZ_HALF: load_extend = {{(DataWidth-16){shifted[15] & ~uns}}, shifted[15:0]};
      default: load_extend = shifted;
    endcase
  endfunction

  assign start      = lsu_en_i & ~en_q & (state_q == IDLE);
  assign misaligned = ((lsu_op_size_i == SZ_HALF) & lsu_addr_i[0]) |
                      (lsu_op_size_i[1] & (lsu_addr_i[1:0] != 2'b00));

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = lsu_wdata_i;
    case (lsu_op_size_i)
      SZ_BYTE: begin
        be_d    = 4'b0001 << lsu_addr_i[1:0];
        wdata_d = {4{lsu_wdata_i[7:0]}};
      end
      SZ_HALF: begin
        be_d    = 4'b0011 << lsu_addr_i[1:0];
        wdata_d = {2{lsu_wdata_i[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = lsu_wdata_i;
      end
    endcase
    if (!lsu_op_i) wdata_d = '0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = misaligned ? ERR : REQ;
      REQ:     if (data_if.data_gnt_i) state_d = WAIT;
      WAIT:    if (data_if.data_rvalid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Responses only count in WAIT; stray rvalids elsewhere are dropped.
  assign rsp      = (state_q == WAIT) & data_if.data_rvalid_i;
  assign rsp_load = rsp & ~data_if.data_err_i & ~op_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
      op_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      be_q    <= 4'b0000;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= lsu_en_i;
      busy_q  <= (state_d != IDLE);
      fault_q <= rsp & data_if.data_err_i;
      if (start) begin
        op_q    <= lsu_op_i;
        uns_q   <= lsu_unsigned_i;
        size_q  <= lsu_op_size_i;
        addr_q  <= lsu_addr_i;
        be_q    <= be_d;
        wdata_q <= wdata_d;
      end
      if (rsp_load) rdata_q <= load_extend(data_if.data_rdata_i, size_q, uns_q, addr_q[1:0]);
    end
  end

  assign lsu_busy_o           = busy_q;
  assign lsu_rdata_o          = rdata_q;
  assign lsu_misaligned_o     = (state_q == ERR);
  assign lsu_fault_o          = fault_q;
  assign data_if.data_req_o   = (state_q == REQ);
  assign data_if.data_addr_o  = {addr_q[AddrWidth-1:2], 2'b00};
  assign data_if.data_we_o    = op_q;
  assign data_if.data_be_o    = be_q;
  assign data_if.data_wdata_o = wdata_q;
endmodule

// File: tb/tb_beta_exe_lsu.sv
// Bench for beta_exe_lsu: directed scenarios plus randomized operations
// checked against a byte-lane reference model.
module tb_beta_exe_lsu;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        lsu_en, lsu_op, lsu_uns;
  logic [1:0]  lsu_size;
  logic [31:0] lsu_addr, lsu_wdata;
  logic        busy, mis, fault;
  logic [31:0] rdata;

  beta_exe_lsu_if bus();

  beta_exe_lsu dut (
    .clk_i            (clk),
    .rstn_i           (rstn),
    .lsu_en_i         (lsu_en),
    .lsu_op_i         (lsu_op),
    .lsu_op_size_i    (lsu_size),
    .lsu_unsigned_i   (lsu_uns),
    .lsu_addr_i       (lsu_addr),
    .lsu_wdata_i      (lsu_wdata),
    .lsu_busy_o       (busy),
    .lsu_rdata_o      (rdata),
    .lsu_misaligned_o (mis),
    .lsu_fault_o      (fault),
    .data_if          (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] mdl_rdata;

  int          obs_req, obs_busy, obs_mis, obs_fault;
  bit          obs_stable, obs_restart, obs_timeout;
  logic [31:0] obs_addr, obs_wdata, obs_rdata;
  logic [3:0]  obs_be;
  logic        obs_we;

  // ---------------- reference model (byte-lane arithmetic) ----------------
  function automatic int m_nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit m_misaligned(input logic [1:0] sz, input logic [31:0] a);
    return (a % m_nbytes(sz)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    logic [3:0] r;
    int o, n;
    o = int'(a % 4);
    n = m_nbytes(sz);
    for (int k = 0; k < 4; k++) r[k] = (k >= o) && (k < o + n);
    return r;
  endfunction

  function automatic logic [31:0] m_wdata(input logic op, input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] r;
    int n;
    n = m_nbytes(sz);
    r = '0;
    if (op) for (int k = 0; k < 4; k++) r[8*k +: 8] = wd[8*(k % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns,
                                         input logic [31:0] a, input logic [31:0] rd);
    longint v, span;
    int o, n;
    o    = int'(a % 4);
    n    = m_nbytes(sz);
    span = longint'(1) << (8 * n);
    v    = longint'(rd);
    v    = (v / (longint'(1) << (8 * o))) % span;
    if (!uns && n < 4 && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  // ---------------- driver: one operation, observations recorded ----------------
  task automatic run_op(input logic op, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int gdly, input int rdly, input logic err,
                        input logic [31:0] rd, input bit hold, input bit noise);
    int  cyc, nwait;
    bit  granted;
    obs_req = 0; obs_busy = 0; obs_mis = 0; obs_fault = 0;
    obs_stable = 1'b1; obs_restart = 1'b0; obs_timeout = 1'b0;
    obs_addr = '0; obs_wdata = '0; obs_be = '0; obs_we = 1'b0;
    cyc = 0; nwait = 0; granted = 1'b0;
    lsu_en = 1'b1; lsu_op = op; lsu_size = sz; lsu_uns = uns;
    lsu_addr = addr; lsu_wdata = wd;
    @(negedge clk);
    if (!hold) lsu_en = 1'b0;
    lsu_addr = $urandom; lsu_wdata = $urandom; lsu_op = ~op;
    while (busy && cyc < 64) begin
      cyc++;
      obs_busy++;
      if (mis) obs_mis++;
      if (bus.data_req_o) begin
        obs_req++;
        if (obs_req == 1) begin
          obs_addr = bus.data_addr_o; obs_be = bus.data_be_o;
          obs_we = bus.data_we_o; obs_wdata = bus.data_wdata_o;
        end else if (bus.data_addr_o !== obs_addr || bus.data_be_o !== obs_be ||
                     bus.data_we_o !== obs_we || bus.data_wdata_o !== obs_wdata) begin
          obs_stable = 1'b0;
        end
        bus.data_gnt_i    = (obs_req > gdly);
        granted           = granted | bus.data_gnt_i;
        bus.data_rvalid_i = noise & $urandom_range(1, 0);
        bus.data_err_i    = $urandom_range(1, 0);
        bus.data_rdata_i  = $urandom;
      end else if (granted) begin
        nwait++;
        bus.data_gnt_i = noise & $urandom_range(1, 0);
        if (nwait > rdly) begin
          bus.data_rvalid_i = 1'b1; bus.data_err_i = err; bus.data_rdata_i = rd;
        end else begin
          bus.data_rvalid_i = 1'b0;
        end
      end else begin
        bus.data_gnt_i = noise & $urandom_range(1, 0);
        bus.data_rvalid_i = noise & $urandom_range(1, 0);
      end
      @(negedge clk);
    end
    if (cyc >= 64) obs_timeout = 1'b1;
    bus.data_gnt_i = 1'b0; bus.data_rvalid_i = 1'b0; bus.data_err_i = 1'b0;
    if (fault) obs_fault++;
    if (mis) obs_mis++;
    obs_rdata = rdata;
    @(negedge clk);
    if (fault) obs_fault++;
    obs_restart = obs_restart | busy;
    @(negedge clk);
    obs_restart = obs_restart | busy;
    lsu_en = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rstn = 1'b0;
    lsu_en = 1'b1; lsu_op = 1'b1; lsu_size = 2'b10; lsu_uns = 1'b0;
    lsu_addr = 32'hFFFF_FFFF; lsu_wdata = 32'hFFFF_FFFF;
    bus.data_gnt_i = 1'b1; bus.data_rvalid_i = 1'b1; bus.data_err_i = 1'b1;
    bus.data_rdata_i = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({busy, mis, fault, bus.data_req_o, bus.data_we_o, bus.data_be_o} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 0", {busy, mis, fault, bus.data_req_o, bus.data_we_o, bus.data_be_o});
    end
    n_tests++;
    if (rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    n_tests++;
    if ({bus.data_addr_o, bus.data_wdata_o} !== 64'd0) begin
      n_fail++; $display("FAIL reset_bus: got %h expected 0", {bus.data_addr_o, bus.data_wdata_o});
    end
    lsu_en = 1'b0;
    bus.data_gnt_i = 1'b0; bus.data_rvalid_i = 1'b0; bus.data_err_i = 1'b0;
    rstn = 1'b1;
    mdl_rdata = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_word_load();
    run_op(1'b0, 2'b10, 1'b0, 32'h1000_0004, 32'h0, 0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    n_tests++;
    if (obs_req !== 1) begin n_fail++; $display("FAIL wl_req_cycles: got %0d expected 1", obs_req); end
    n_tests++;
    if (obs_be !== 4'b1111 || obs_addr !== 32'h1000_0004 || obs_we !== 1'b0) begin
      n_fail++; $display("FAIL wl_bus: got be=%b addr=%h we=%b expected be=1111 addr=10000004 we=0", obs_be, obs_addr, obs_we);
    end
    n_tests++;
    if (obs_busy !== 2) begin n_fail++; $display("FAIL wl_busy: got %0d expected 2", obs_busy); end
    n_tests++;
    if (obs_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wl_rdata: got %h expected deadbeef", obs_rdata); end
    mdl_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic test_byte_loads();
    run_op(1'b0, 2'b00, 1'b0, 32'h1000_0003, 32'h0, 0, 0, 1'b0, 32'h8011_2233, 1'b0, 1'b0);
    n_tests++;
    if (obs_rdata !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_rdata: got %h expected ffffff80", obs_rdata); end
    run_op(1'b0, 2'b00, 1'b1, 32'h1000_0003, 32'h0, 1, 1, 1'b0, 32'h8011_2233, 1'b0, 1'b0);
    n_tests++;
    if (obs_rdata !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_rdata: got %h expected 00000080", obs_rdata); end
    n_tests++;
    if (obs_be !== 4'b1000) begin n_fail++; $display("FAIL lbu_be: got %b expected 1000", obs_be); end
    run_op(1'b0, 2'b01, 1'b0, 32'h1000_0002, 32'h0, 0, 2, 1'b0, 32'h8011_2233, 1'b0, 1'b0);
    n_tests++;
    if (obs_rdata !== 32'hFFFF_8011) begin n_fail++; $display("FAIL lh_rdata: got %h expected ffff8011", obs_rdata); end
    mdl_rdata = 32'hFFFF_8011;
  endtask

  task automatic test_half_store();
    run_op(1'b1, 2'b01, 1'b0, 32'h2000_0002, 32'h0000_ABCD, 0, 0, 1'b0, 32'h5555_5555, 1'b0, 1'b0);
    n_tests++;
    if (obs_addr !== 32'h2000_0000 || obs_be !== 4'b1100) begin
      n_fail++; $display("FAIL sh_addr_be: got addr=%h be=%b expected addr=20000000 be=1100", obs_addr, obs_be);
    end
    n_tests++;
    if (obs_wdata !== 32'hABCD_ABCD || obs_we !== 1'b1) begin
      n_fail++; $display("FAIL sh_wdata: got wdata=%h we=%b expected abcdabcd we=1", obs_wdata, obs_we);
    end
    n_tests++;
    if (obs_busy !== 2 || obs_rdata !== mdl_rdata) begin
      n_fail++; $display("FAIL sh_done: got busy=%0d rdata=%h expected busy=2 rdata=%h", obs_busy, obs_rdata, mdl_rdata);
    end
  endtask

  task automatic test_grant_stall();
    run_op(1'b1, 2'b10, 1'b0, 32'h4000_0008, 32'h1234_5678, 3, 1, 1'b0, 32'h0, 1'b1, 1'b0);
    n_tests++;
    if (obs_req !== 4 || obs_stable !== 1'b1) begin
      n_fail++; $display("FAIL stall_req: got cycles=%0d stable=%b expected cycles=4 stable=1", obs_req, obs_stable);
    end
    n_tests++;
    if (obs_busy !== 6) begin n_fail++; $display("FAIL stall_busy: got %0d expected 6", obs_busy); end
    n_tests++;
    if (obs_restart !== 1'b0) begin n_fail++; $display("FAIL stall_restart: got %b expected 0", obs_restart); end
  endtask

  task automatic test_misaligned();
    run_op(1'b0, 2'b10, 1'b0, 32'h5000_0001, 32'h0, 0, 0, 1'b0, 32'h1111_1111, 1'b0, 1'b0);
    n_tests++;
    if (obs_req !== 0) begin n_fail++; $display("FAIL mis_req: got %0d expected 0", obs_req); end
    n_tests++;
    if (obs_busy !== 1 || obs_mis !== 1) begin
      n_fail++; $display("FAIL mis_pulse: got busy=%0d mis=%0d expected 1 1", obs_busy, obs_mis);
    end
    n_tests++;
    if (obs_rdata !== mdl_rdata) begin n_fail++; $display("FAIL mis_rdata: got %h expected %h", obs_rdata, mdl_rdata); end
  endtask

  task automatic test_bus_error();
    run_op(1'b0, 2'b10, 1'b0, 32'h6000_0000, 32'h0, 1, 0, 1'b1, 32'h7777_7777, 1'b0, 1'b0);
    n_tests++;
    if (obs_fault !== 1) begin n_fail++; $display("FAIL err_fault: got %0d expected 1", obs_fault); end
    n_tests++;
    if (obs_rdata !== mdl_rdata) begin n_fail++; $display("FAIL err_rdata: got %h expected %h", obs_rdata, mdl_rdata); end
  endtask

  task automatic test_reset_mid_op();
    lsu_en = 1'b1; lsu_op = 1'b0; lsu_size = 2'b10; lsu_uns = 1'b0; lsu_addr = 32'h3000_0000;
    @(negedge clk);
    lsu_en = 1'b0;
    bus.data_gnt_i = 1'b1;
    @(negedge clk);
    bus.data_gnt_i = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || bus.data_req_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_wait: got busy=%b req=%b expected 1 0", busy, bus.data_req_o);
    end
    rstn = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b0 || bus.data_req_o !== 1'b0 || rdata !== 32'd0) begin
      n_fail++; $display("FAIL rst_async: got busy=%b req=%b rdata=%h expected 0 0 0", busy, bus.data_req_o, rdata);
    end
    @(negedge clk);
    rstn = 1'b1;
    mdl_rdata = '0;
    @(negedge clk);
    bus.data_rvalid_i = 1'b1; bus.data_err_i = 1'b0; bus.data_rdata_i = 32'hCAFE_F00D;
    @(negedge clk);
    bus.data_rvalid_i = 1'b0;
    n_tests++;
    if (rdata !== mdl_rdata || busy !== 1'b0 || fault !== 1'b0) begin
      n_fail++; $display("FAIL rst_late_rvalid: got rdata=%h busy=%b fault=%b expected %h 0 0", rdata, busy, fault, mdl_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++) begin
      logic        op, uns, err;
      logic [1:0]  sz;
      logic [31:0] addr, wd, rd, exp_rd;
      int          gdly, rdly, n;
      bit          m;
      op = $urandom_range(1, 0); uns = $urandom_range(1, 0);
      sz = $urandom_range(3, 0); err = ($urandom_range(9, 0) == 0);
      addr = $urandom; wd = $urandom; rd = $urandom;
      n = m_nbytes(sz);
      if ($urandom_range(3, 0) != 0) addr = addr - (addr % n);
      gdly = $urandom_range(3, 0); rdly = $urandom_range(3, 0);
      m = m_misaligned(sz, addr);
      run_op(op, sz, uns, addr, wd, gdly, rdly, err, rd, $urandom_range(1, 0), 1'b1);
      exp_rd = (!m && !op && !err) ? m_load(sz, uns, addr, rd) : mdl_rdata;
      n_tests++;
      if (obs_timeout || obs_restart) begin
        n_fail++; $display("FAIL rnd_term[%0d]: got timeout=%b restart=%b expected 0 0", i, obs_timeout, obs_restart);
      end
      n_tests++;
      if (obs_req !== (m ? 0 : gdly + 1) || obs_busy !== (m ? 1 : gdly + rdly + 2)) begin
        n_fail++; $display("FAIL rnd_timing[%0d]: got req=%0d busy=%0d expected req=%0d busy=%0d",
                           i, obs_req, obs_busy, m ? 0 : gdly + 1, m ? 1 : gdly + rdly + 2);
      end
      n_tests++;
      if (obs_mis !== int'(m) || obs_fault !== int'(!m && err)) begin
        n_fail++; $display("FAIL rnd_flags[%0d]: got mis=%0d fault=%0d expected %0d %0d", i, obs_mis, obs_fault, m, !m && err);
      end
      n_tests++;
      if (obs_rdata !== exp_rd) begin n_fail++; $display("FAIL rnd_rdata[%0d]: got %h expected %h", i, obs_rdata, exp_rd); end
      if (!m) begin
        n_tests++;
        if (obs_addr !== {addr[31:2], 2'b00} || obs_be !== m_be(sz, addr) || obs_we !== op ||
            obs_wdata !== m_wdata(op, sz, wd) || obs_stable !== 1'b1) begin
          n_fail++; $display("FAIL rnd_bus[%0d]: got addr=%h be=%b we=%b wdata=%h stable=%b expected addr=%h be=%b we=%b wdata=%h",
                             i, obs_addr, obs_be, obs_we, obs_wdata, obs_stable,
                             {addr[31:2], 2'b00}, m_be(sz, addr), op, m_wdata(op, sz, wd));
        end
      end
      mdl_rdata = exp_rd;
    end
  endtask

  initial begin
    rstn = 1'b0; lsu_en = 1'b0; lsu_op = 1'b0; lsu_size = 2'b00; lsu_uns = 1'b0;
    lsu_addr = '0; lsu_wdata = '0;
    bus.data_gnt_i = 1'b0; bus.data_rvalid_i = 1'b0; bus.data_err_i = 1'b0; bus.data_rdata_i = '0;
    mdl_rdata = '0;
    test_reset();
    test_word_load();
    test_byte_loads();
    test_half_store();
    test_grant_stall();
    test_misaligned();
    test_bus_error();
    test_reset_mid_op();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
